// File: rtl/mc10_vctl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mc10_vctl_pkg
// Purpose : Shared definitions for the MC-10 video-control register bank:
//           CPU port-select encodings, key-unlock FSM state type and the
//           default unlock key bytes.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mc10_vctl_pkg;

  // Port select, taken from cpu_addr[1:0]
  localparam logic [1:0] SEL_LEGACY = 2'b00;
  localparam logic [1:0] SEL_INDEX  = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_KEY    = 2'b11;

  // Key-unlock FSM states
  typedef enum logic [1:0] {
    LOCKED    = 2'd0,
    KEY1_WAIT = 2'd1,
    UNLOCKED  = 2'd2
  } vctl_state_e;

  // Default unlock sequence
  localparam logic [7:0] KEY0_DEFAULT = 8'hA5;
  localparam logic [7:0] KEY1_DEFAULT = 8'h5A;

endpackage : mc10_vctl_pkg
`default_nettype wire

// File: rtl/mc10_vctl_unlock_fsm.sv
`default_nettype none
// ============================================================================
// Module  : mc10_vctl_unlock_fsm
// Purpose : Two-byte key sequence that guards the extended video-control
//           registers. Every U8_clock rising edge is one CPU write.
// Ports   : U8_clock     in  write strobe
//           RESET        in  async, active-high
//           sel          in  port select of the current write
//           din          in  low byte of the current write data
//           unlocked     out registered, 1 while in UNLOCKED
//           unlock_pulse out high during the write that completes the
//                            sequence (used to clear the index pointer)
// Rev     : 1.0  initial release
// ============================================================================
module mc10_vctl_unlock_fsm
  import mc10_vctl_pkg::*;
#(
  parameter logic [7:0] KEY0 = KEY0_DEFAULT,
  parameter logic [7:0] KEY1 = KEY1_DEFAULT
) (
  input  logic       U8_clock,
  input  logic       RESET,
  input  logic [1:0] sel,
  input  logic [7:0] din,
  output logic       unlocked,
  output logic       unlock_pulse
);

  vctl_state_e state_q;
  logic        unlocked_q;

  logic w_key_wr;
  assign w_key_wr = (sel == SEL_KEY);

  // Qualified by the current write so the top can clear the index on the
  // same edge that the FSM enters UNLOCKED.
  assign unlock_pulse = (state_q == KEY1_WAIT) && w_key_wr && (din == KEY1);

  always_ff @(posedge U8_clock or posedge RESET) begin
    if (RESET) begin
      state_q    <= LOCKED;
      unlocked_q <= 1'b0;
    end else begin
      case (state_q)
        LOCKED: begin
          if (w_key_wr && (din == KEY0)) begin
            state_q <= KEY1_WAIT;
          end
          unlocked_q <= 1'b0;
        end
        KEY1_WAIT: begin
          // Anything other than the exact second key breaks the sequence.
          if (w_key_wr && (din == KEY1)) begin
            state_q    <= UNLOCKED;
            unlocked_q <= 1'b1;
          end else begin
            state_q    <= LOCKED;
            unlocked_q <= 1'b0;
          end
        end
        UNLOCKED: begin
          // Any key-port write relocks, whatever the value.
          if (w_key_wr) begin
            state_q    <= LOCKED;
            unlocked_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= LOCKED;
          unlocked_q <= 1'b0;
        end
      endcase
    end
  end

  assign unlocked = unlocked_q;

endmodule : mc10_vctl_unlock_fsm
`default_nettype wire

// File: rtl/mc10_vctl_regs.sv
`default_nettype none
// ============================================================================
// Module  : mc10_vctl_regs
// Purpose : NREGS x DW video-control register bank for extended MC-10 modes.
//           reg0 keeps the legacy 6-bit VDG mode latch encoding; the other
//           registers are reachable only after the key-unlock sequence.
// Config  : MC10_VCTL_READBACK_EN - adds rd_idx/rd_data readback ports.
// Ports   : U8_clock  in  write strobe (rising edge = one CPU write)
//           RESET     in  async, active-high
//           din       in  CPU write data
//           sel       in  00 legacy, 01 index, 10 data, 11 key
//           an_g, gm, css, intn_ext  out  VDG mode decode of reg0
//           regs_flat out reg[i] at bits [i*DW +: DW]
//           unlocked  out 1 while the key FSM is UNLOCKED
//           index     out current index pointer
//           rd_idx    in  readback select   (MC10_VCTL_READBACK_EN)
//           rd_data   out readback data     (MC10_VCTL_READBACK_EN)
// Rev     : 1.0  initial release
// ============================================================================
module mc10_vctl_regs
  import mc10_vctl_pkg::*;
#(
  parameter int         DW      = 8,
  parameter int         NREGS   = 8,
  parameter int         IDXW    = $clog2(NREGS),
  parameter logic [7:0] KEY0    = KEY0_DEFAULT,
  parameter logic [7:0] KEY1    = KEY1_DEFAULT,
  parameter int         AUTOINC = 1
) (
  input  logic                  U8_clock,
  input  logic                  RESET,
  input  logic [DW-1:0]         din,
  input  logic [1:0]            sel,
  output logic                  an_g,
  output logic [2:0]            gm,
  output logic                  css,
  output logic                  intn_ext,
  output logic [NREGS*DW-1:0]   regs_flat,
  output logic                  unlocked,
  output logic [IDXW-1:0]       index
`ifdef MC10_VCTL_READBACK_EN
  ,
  input  logic [IDXW-1:0]       rd_idx,
  output logic [DW-1:0]         rd_data
`endif
);

  logic [DW-1:0]   regs_q [NREGS];
  logic [DW-1:0]   regs_d [NREGS];
  logic [IDXW-1:0] index_q;
  logic [IDXW-1:0] index_d;

  logic w_unlocked;
  logic w_unlock_pulse;
  logic w_idx_valid;
  logic w_idx_last;

  mc10_vctl_unlock_fsm #(
    .KEY0 (KEY0),
    .KEY1 (KEY1)
  ) u_unlock_fsm (
    .U8_clock     (U8_clock),
    .RESET        (RESET),
    .sel          (sel),
    .din          (din[7:0]),
    .unlocked     (w_unlocked),
    .unlock_pulse (w_unlock_pulse)
  );

  // With a non-power-of-two NREGS the pointer can address past the bank.
  assign w_idx_valid = (32'(index_q) <  NREGS);
  assign w_idx_last  = (32'(index_q) >= NREGS - 1);

  always_comb begin
    regs_d  = regs_q;
    index_d = index_q;
    case (sel)
      SEL_LEGACY: begin
        // Legacy latch: din[7:2] lands in reg0[5:0], upper bits kept.
        regs_d[0][5:0] = din[7:2];
      end
      SEL_INDEX: begin
        if (w_unlocked) begin
          index_d = din[IDXW-1:0];
        end
      end
      SEL_DATA: begin
        if (w_unlocked) begin
          if (w_idx_valid) begin
            regs_d[index_q] = din;
          end
          // Advance even on a dropped write so the pointer always wraps.
          if (AUTOINC != 0) begin
            index_d = w_idx_last ? '0 : index_q + 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
    if (w_unlock_pulse) begin
      index_d = '0;
    end
  end

  always_ff @(posedge U8_clock or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      index_q <= '0;
    end else begin
      regs_q  <= regs_d;
      index_q <= index_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
      assign regs_flat[gi*DW +: DW] = regs_q[gi];
    end
  endgenerate

  // VDG mode decode of reg0 (legacy bit positions).
  assign an_g     = regs_q[0][3];
  assign gm       = {regs_q[0][0], regs_q[0][1], regs_q[0][2]};
  assign css      = regs_q[0][4];
  assign intn_ext = regs_q[0][0];
  assign unlocked = w_unlocked;
  assign index    = index_q;

`ifdef MC10_VCTL_READBACK_EN
  // reg0 is always visible; the extended registers only while unlocked.
  always_comb begin
    rd_data = '0;
    if ((32'(rd_idx) < NREGS) && (w_unlocked || (rd_idx == '0))) begin
      rd_data = regs_q[rd_idx];
    end
  end
`endif

endmodule : mc10_vctl_regs
`default_nettype wire

// File: tb/tb_mc10_vctl_regs.sv
`default_nettype none
// ============================================================================
// Module  : tb_mc10_vctl_regs
// Purpose : Self-checking bench for mc10_vctl_regs (default parameters).
//           Directed scenarios followed by random writes, all compared
//           against a behavioural model of the register bank.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mc10_vctl_regs;

  logic        U8_clock;
  logic        RESET;
  logic [7:0]  din;
  logic [1:0]  sel;
  logic        an_g;
  logic [2:0]  gm;
  logic        css;
  logic        intn_ext;
  logic [63:0] regs_flat;
  logic        unlocked;
  logic [2:0]  index;
`ifdef MC10_VCTL_READBACK_EN
  logic [2:0]  rd_idx;
  logic [7:0]  rd_data;
`endif

  mc10_vctl_regs dut (
    .U8_clock  (U8_clock),
    .RESET     (RESET),
    .din       (din),
    .sel       (sel),
    .an_g      (an_g),
    .gm        (gm),
    .css       (css),
    .intn_ext  (intn_ext),
    .regs_flat (regs_flat),
    .unlocked  (unlocked),
    .index     (index)
`ifdef MC10_VCTL_READBACK_EN
    ,
    .rd_idx    (rd_idx),
    .rd_data   (rd_data)
`endif
  );

  initial U8_clock = 1'b0;
  always #5 U8_clock = ~U8_clock;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model: register contents, pointer and two unlock flags.
  logic [7:0] m_regs [8];
  int         m_index;
  bit         m_unl;
  bit         m_armed;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_index = 0;
    m_unl   = 1'b0;
    m_armed = 1'b0;
  endfunction

  function automatic void model_write(logic [1:0] s, logic [7:0] d);
    bit was_unl   = m_unl;
    bit was_armed = m_armed;
    if (s == 2'd0) m_regs[0][5:0] = d[7:2];
    if (s == 2'd1 && was_unl) m_index = int'(d[2:0]);
    if (s == 2'd2 && was_unl) begin
      m_regs[m_index] = d;
      m_index = (m_index + 1) % 8;
    end
    m_armed = !was_unl && !was_armed && s == 2'd3 && d == 8'hA5;
    if (was_armed && s == 2'd3 && d == 8'h5A) begin
      m_unl   = 1'b1;
      m_index = 0;
    end
    if (was_unl && s == 2'd3) m_unl = 1'b0;
  endfunction

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [7:0] r0;
    r0 = m_regs[0];
    chk({tag, ".regs"},     regs_flat, model_flat());
    chk({tag, ".index"},    64'(index), 64'(m_index));
    chk({tag, ".unlocked"}, 64'(unlocked), 64'(m_unl));
    chk({tag, ".an_g"},     64'(an_g), 64'(r0[3]));
    chk({tag, ".gm"},       64'(gm), 64'({r0[0], r0[1], r0[2]}));
    chk({tag, ".css"},      64'(css), 64'(r0[4]));
    chk({tag, ".intn"},     64'(intn_ext), 64'(r0[0]));
`ifdef MC10_VCTL_READBACK_EN
    begin
      int ri;
      ri = int'($urandom_range(0, 7));
      rd_idx = 3'(ri);
      #1;
      chk({tag, ".rd"}, 64'(rd_data), 64'((ri == 0 || m_unl) ? m_regs[ri] : 8'h00));
    end
`endif
  endtask

  // One CPU write: inputs are stable well before the edge, outputs are
  // sampled 1 ns after it.
  task automatic wr(input logic [1:0] s, input logic [7:0] d, input string tag);
    sel = s;
    din = d;
    @(posedge U8_clock);
    model_write(s, d);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    RESET = 1'b1;
    #2;
    model_reset();
    check_all(tag);
    @(posedge U8_clock);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    sel   = 2'd0;
    din   = 8'h00;
`ifdef MC10_VCTL_READBACK_EN
    rd_idx = 3'd0;
`endif
    model_reset();
    #2;
    check_all("reset");
    @(posedge U8_clock);
    #1;
    RESET = 1'b0;

    // Legacy write
    wr(2'd0, 8'h2C, "legacy");
    chk("legacy.reg0", 64'(regs_flat[5:0]), 64'h0B);
    chk("legacy.an_g", 64'(an_g), 64'd1);

    // Locked: index/data ports ignored
    wr(2'd1, 8'h03, "locked_idx");
    wr(2'd2, 8'hFF, "locked_data");

    // Unlock, fill the bank, pointer wraps
    wr(2'd3, 8'hA5, "key0");
    wr(2'd3, 8'h5A, "key1");
    chk("unlock.flag", 64'(unlocked), 64'd1);
    for (int i = 1; i <= 8; i++) wr(2'd2, 8'(i * 8'h11), "fill");
    chk("fill.flat", regs_flat, 64'h8877_6655_4433_2211);
    chk("fill.wrap", 64'(index), 64'd0);
`ifdef MC10_VCTL_READBACK_EN
    rd_idx = 3'd5;
    #1;
    chk("rb.unl5", 64'(rd_data), 64'h66);
`endif

    // Explicit index then data at the last slot
    wr(2'd1, 8'h07, "idx7");
    wr(2'd2, 8'h99, "data7");
    chk("data7.wrap", 64'(index), 64'd0);

    // Relock with any key value; contents retained
    wr(2'd3, 8'h00, "relock");
    chk("relock.reg7", 64'(regs_flat[63:56]), 64'h99);
`ifdef MC10_VCTL_READBACK_EN
    rd_idx = 3'd5;
    #1;
    chk("rb.lock5", 64'(rd_data), 64'h00);
    rd_idx = 3'd0;
    #1;
    chk("rb.lock0", 64'(rd_data), 64'(regs_flat[7:0]));
`endif

    // Broken sequence: legacy write between keys still applies
    wr(2'd3, 8'hA5, "brk.key0");
    wr(2'd0, 8'h04, "brk.legacy");
    wr(2'd3, 8'h5A, "brk.key1");
    chk("brk.reg0", 64'(regs_flat[5:0]), 64'h01);
    chk("brk.locked", 64'(unlocked), 64'd0);

    // Reset while waiting for the second key
    wr(2'd3, 8'hA5, "rst.key0");
    pulse_reset("rst.mid");
    wr(2'd3, 8'h5A, "rst.key1");
    chk("rst.locked", 64'(unlocked), 64'd0);

    // Random writes, keys biased so unlocks occur often
    for (int n = 0; n < 300; n++) begin
      logic [1:0] s;
      logic [7:0] d;
      s = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       d = 8'hA5;
        1:       d = 8'h5A;
        default: d = 8'($urandom);
      endcase
      if (s == 2'd3 && $urandom_range(0, 1) == 1) s = 2'd2;
      wr(s, d, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mc10_vctl_regs
`default_nettype wire
